bcd_serial_adder: RTL and testbench

Digit-serial packed-BCD adder, the arithmetic stage directly downstream of the APB summator register block. It latches two BCD operands on a start request, adds them one 4-bit digit per clock from the least significant digit, and returns the BCD sum, a decimal overflow (carry-out) flag and a busy/done handshake. The summator polls these outputs through its status and result registers.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_digit_add.sv | 19 +
 rtl/bcd_serial_adder.sv | 114 +++++++++++
 tb/tb_bcd_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGIT  = 9;
  localparam int BCD_CORRECTION = 6;
endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add with decimal correction; time-shared by the serial adder.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] s;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout = s > 5'(BCD_MAX_DIGIT);
    // (s + 6)[3:0] only depends on s[3:0]
    sum  = cout ? s[3:0] + 4'(BCD_CORRECTION) : s[3:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock.
// Optional operand checking: BCD_SERIAL_ADDER_INVALID_CHECK_EN.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int ARG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ARG_WIDTH-1:0] arg1,
  input  logic [ARG_WIDTH-1:0] arg2,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ARG_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 invalid
);
  localparam int DIGITS = ARG_WIDTH / BCD_DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t               state, state_nxt;
  logic [ARG_WIDTH-1:0] a_sh, b_sh;
  logic                 carry;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           dsum;
  logic                 dcout;
  logic                 accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_W'(DIGITS - 1));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  bcd_digit_add u_digit (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

`ifdef BCD_SERIAL_ADDER_INVALID_CHECK_EN
  logic arg_bad, bad;

  always_comb begin
    arg_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (arg1[i*4 +: 4] > 4'(BCD_MAX_DIGIT) || arg2[i*4 +: 4] > 4'(BCD_MAX_DIGIT))
        arg_bad = 1'b1;
  end
`else
  assign invalid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef BCD_SERIAL_ADDER_INVALID_CHECK_EN
      bad      <= 1'b0;
      invalid  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh     <= arg1;
      b_sh     <= arg2;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef BCD_SERIAL_ADDER_INVALID_CHECK_EN
      bad      <= arg_bad;
      invalid  <= 1'b0;
`endif
    end else if (state == CALC) begin
      a_sh  <= a_sh >> BCD_DIGIT_W;
      b_sh  <= b_sh >> BCD_DIGIT_W;
      carry <= dcout;
      if (!last) cnt <= cnt + 1'b1;
      for (int i = 0; i < DIGITS; i++)
        if (cnt == CNT_W'(i)) result[i*4 +: 4] <= dsum;
      if (last) begin
        overflow <= dcout;
`ifdef BCD_SERIAL_ADDER_INVALID_CHECK_EN
        // bad operands: run full length for fixed timing, then report zero
        if (bad) begin
          result   <= '0;
          overflow <= 1'b0;
          invalid  <= 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: decimal reference model, latency and handshake checks.
module tb_bcd_serial_adder;
  localparam int W      = 32;
  localparam int DIGITS = W / 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         inv;
  } exp_t;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] arg1 = '0, arg2 = '0;
  logic         busy, done, overflow, invalid;
  logic [W-1:0] result;

  exp_t sb[$];
  int   compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.ARG_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .arg1(arg1), .arg2(arg2), .start(start),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .invalid(invalid)
  );

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal addition of valid BCD operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   m;
    longint lim = 1;
    longint s;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    s     = bcd2int(a) + bcd2int(b);
    m.ovf = (s >= lim);
    m.res = int2bcd(s % lim);
    m.inv = 1'b0;
    return m;
  endfunction

  // Waits (bounded) for done; counts negedges since acceptance and busy cycles seen.
  task automatic wait_done(input bit drop, input int inj, input logic [W-1:0] junk,
                           output int e, output int nb);
    e  = 0;
    nb = 0;
    while (e < 20) begin
      @(negedge clk);
      e++;
      if (drop && e == 1) start = 1'b0;
      if (inj > 0 && e == inj) begin
        arg1 = junk; arg2 = ~junk; start = 1'b1;
      end else if (inj > 0 && e == inj + 1) start = 1'b0;
      if (busy) nb++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared += 5;
    if (busy !== 1'b0)     begin mismatched++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)     begin mismatched++; $display("FAIL rst_done got %b want 0", done); end
    if (result !== '0)     begin mismatched++; $display("FAIL rst_result got %h want 0", result); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_ovf got %b want 0", overflow); end
    if (invalid !== 1'b0)  begin mismatched++; $display("FAIL rst_inv got %b want 0", invalid); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [W-1:0] ta[8], tb_[8];
    exp_t x;
    int   e, nb;
    ta[0] = 32'h0000_0019; tb_[0] = 32'h0000_0001;
    ta[1] = 32'h9999_9999; tb_[1] = 32'h0000_0001;
    ta[2] = 32'h1234_5678; tb_[2] = 32'h8765_4321;
    ta[3] = 32'h9999_9999; tb_[3] = 32'h9999_9999;
    for (int i = 4; i < 8; i++) begin
      ta[i]  = int2bcd(longint'($urandom_range(0, 99999999)));
      tb_[i] = int2bcd(longint'($urandom_range(0, 99999999)));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      arg1 = ta[i]; arg2 = tb_[i]; start = 1'b1;
      sb.push_back(model(ta[i], tb_[i]));
      wait_done(1'b1, 0, '0, e, nb);
      x = (sb.size() > 0) ? sb.pop_front() : '0;
      compared += 5;
      if (e !== 9)         begin mismatched++; $display("FAIL add%0d_latency got %0d want 9", i, e); end
      if (nb !== 8)        begin mismatched++; $display("FAIL add%0d_busy got %0d want 8", i, nb); end
      if (result !== x.res)   begin mismatched++; $display("FAIL add%0d_result got %h want %h", i, result, x.res); end
      if (overflow !== x.ovf) begin mismatched++; $display("FAIL add%0d_ovf got %b want %b", i, overflow, x.ovf); end
      if (invalid !== x.inv)  begin mismatched++; $display("FAIL add%0d_inv got %b want %b", i, invalid, x.inv); end
    end
  endtask

  task automatic test_ignore_start();
    exp_t x;
    int   e, nb;
    @(negedge clk);
    arg1 = 32'h0000_4567; arg2 = 32'h0000_5555; start = 1'b1;
    sb.push_back(model(32'h0000_4567, 32'h0000_5555));
    wait_done(1'b1, 4, 32'h0101_0101, e, nb);
    x = (sb.size() > 0) ? sb.pop_front() : '0;
    compared += 4;
    if (e !== 9)            begin mismatched++; $display("FAIL ign_latency got %0d want 9", e); end
    if (nb !== 8)           begin mismatched++; $display("FAIL ign_busy got %0d want 8", nb); end
    if (result !== x.res)   begin mismatched++; $display("FAIL ign_result got %h want %h", result, x.res); end
    if (overflow !== x.ovf) begin mismatched++; $display("FAIL ign_ovf got %b want %b", overflow, x.ovf); end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int   e, nb;
    @(negedge clk);
    arg1 = 32'h1111_1111; arg2 = 32'h2222_2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compared += 5;
    if (busy !== 1'b0)     begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
    if (done !== 1'b0)     begin mismatched++; $display("FAIL mid_done got %b want 0", done); end
    if (result !== '0)     begin mismatched++; $display("FAIL mid_result got %h want 0", result); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL mid_ovf got %b want 0", overflow); end
    if (invalid !== 1'b0)  begin mismatched++; $display("FAIL mid_inv got %b want 0", invalid); end
    @(negedge clk);
    arg1 = 32'h5; arg2 = 32'h5; start = 1'b1;
    sb.push_back(model(32'h5, 32'h5));
    wait_done(1'b1, 0, '0, e, nb);
    x = (sb.size() > 0) ? sb.pop_front() : '0;
    compared += 2;
    if (e !== 9)          begin mismatched++; $display("FAIL mid_post_latency got %0d want 9", e); end
    if (result !== x.res) begin mismatched++; $display("FAIL mid_post_result got %h want %h", result, x.res); end
  endtask

  task automatic test_invalid();
    exp_t x, want;
    int   e, nb;
`ifdef BCD_SERIAL_ADDER_INVALID_CHECK_EN
    want = '{res: '0, ovf: 1'b0, inv: 1'b1};
`else
    want = '{res: 32'h0000_0010, ovf: 1'b0, inv: 1'b0};
`endif
    @(negedge clk);
    arg1 = 32'h0000_000A; arg2 = 32'h0; start = 1'b1;
    sb.push_back(want);
    wait_done(1'b1, 0, '0, e, nb);
    x = (sb.size() > 0) ? sb.pop_front() : '0;
    compared += 4;
    if (e !== 9)            begin mismatched++; $display("FAIL inv_latency got %0d want 9", e); end
    if (result !== x.res)   begin mismatched++; $display("FAIL inv_result got %h want %h", result, x.res); end
    if (overflow !== x.ovf) begin mismatched++; $display("FAIL inv_ovf got %b want %b", overflow, x.ovf); end
    if (invalid !== x.inv)  begin mismatched++; $display("FAIL inv_flag got %b want %b", invalid, x.inv); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   e, nb;
    @(negedge clk);
    arg1 = 32'h0000_0808; arg2 = 32'h0000_0303; start = 1'b1;
    sb.push_back(model(32'h0000_0808, 32'h0000_0303));
    wait_done(1'b0, 0, '0, e, nb);
    x = (sb.size() > 0) ? sb.pop_front() : '0;
    compared += 2;
    if (e !== 9)          begin mismatched++; $display("FAIL b2b1_latency got %0d want 9", e); end
    if (result !== x.res) begin mismatched++; $display("FAIL b2b1_result got %h want %h", result, x.res); end
    // start still high in DONE: next op is accepted on the coming edge
    arg1 = 32'h5000_0000; arg2 = 32'h4999_9999;
    sb.push_back(model(32'h5000_0000, 32'h4999_9999));
    @(negedge clk);
    start = 1'b0;
    compared += 2;
    if (done !== 1'b0) begin mismatched++; $display("FAIL b2b_done_width got %b want 0", done); end
    if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
    wait_done(1'b0, 0, '0, e, nb);
    x = (sb.size() > 0) ? sb.pop_front() : '0;
    compared += 4;
    if (e !== 8)            begin mismatched++; $display("FAIL b2b2_latency got %0d want 8", e); end
    if (nb !== 7)           begin mismatched++; $display("FAIL b2b2_busy got %0d want 7", nb); end
    if (result !== x.res)   begin mismatched++; $display("FAIL b2b2_result got %h want %h", result, x.res); end
    if (overflow !== x.ovf) begin mismatched++; $display("FAIL b2b2_ovf got %b want %b", overflow, x.ovf); end
    @(negedge clk);
    compared += 1;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_reset_mid();
    test_invalid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
